// File: rtl/mem_if_pkg.sv
// Shared data-memory interface definitions: store size codes and big-endian lane helpers,
// used by the data-memory responder and the MEM-stage store path.
package mem_if_pkg;

  localparam logic [1:0] DM_SIZE_WORD = 2'd0;
  localparam logic [1:0] DM_SIZE_BYTE = 2'd1;
  localparam logic [1:0] DM_SIZE_HALF = 2'd2;
  localparam logic [1:0] DM_SIZE_TRI  = 2'd3;

  // be[k] enables data[8k+7:8k], so lane0 ([31:24]) is be[3].
  typedef struct packed {
    logic [3:0] be;
    logic       legal;
  } lane_dec_t;

  function automatic lane_dec_t lane_decode(input logic [1:0] size, input logic [1:0] a);
    lane_dec_t d;
    d.be    = 4'b0000;
    d.legal = 1'b0;
    case (size)
      DM_SIZE_WORD: if (a == 2'd0) begin d.be = 4'b1111; d.legal = 1'b1; end
      DM_SIZE_BYTE: begin d.be = 4'b1000 >> a; d.legal = 1'b1; end
      DM_SIZE_HALF: begin
        if (a == 2'd0)      begin d.be = 4'b1100; d.legal = 1'b1; end
        else if (a == 2'd2) begin d.be = 4'b0011; d.legal = 1'b1; end
      end
      default: begin
        if (a == 2'd0)      begin d.be = 4'b1110; d.legal = 1'b1; end
        else if (a == 2'd1) begin d.be = 4'b0111; d.legal = 1'b1; end
      end
    endcase
    return d;
  endfunction

  // Moves right-justified store data so its last byte sits in the last enabled lane.
  function automatic logic [31:0] lane_align(input logic [1:0] size, input logic [1:0] a,
                                             input logic [31:0] data);
    logic [31:0] r;
    case (size)
      DM_SIZE_WORD: r = data;
      DM_SIZE_BYTE: r = data << {~a, 3'b000};
      DM_SIZE_HALF: r = (a == 2'd0) ? (data << 16) : data;
      default:      r = (a == 2'd0) ? (data << 8) : data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_write_buffer.sv
// Coalescing store FIFO: entry 0 is the oldest; a store to the youngest entry's word merges
// into it, and reads see RAM data overlaid by every matching entry, oldest to youngest.
module dm_write_buffer #(
  parameter int AW    = 10,
  parameter int DEPTH = 2,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push,
  input  logic [AW-1:0] push_word,
  input  logic [31:0]   push_data,
  input  logic [3:0]    push_be,
  input  logic          drain_req,
  output logic          drain_valid,
  output logic [AW-1:0] drain_word,
  output logic [31:0]   drain_data,
  output logic [3:0]    drain_be,
  input  logic [AW-1:0] fwd_word,
  input  logic [31:0]   fwd_base,
  output logic [31:0]   fwd_data,
  output logic [LW-1:0] level
);

  logic [AW-1:0] word_reg [DEPTH];
  logic [31:0]   data_reg [DEPTH];
  logic [3:0]    be_reg   [DEPTH];
  logic [LW-1:0] level_reg;

  logic [AW-1:0] word_next [DEPTH];
  logic [31:0]   data_next [DEPTH];
  logic [3:0]    be_next   [DEPTH];
  logic [LW-1:0] level_next;

  logic [31:0]   m_data [DEPTH];
  logic [3:0]    m_be   [DEPTH];
  logic          coalesce;

  // Merge lands before the pop, so a drained youngest entry carries the new bytes to RAM.
  always_comb begin
    m_data   = data_reg;
    m_be     = be_reg;
    coalesce = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (push && int'(level_reg) == i + 1 && word_reg[i] == push_word) begin
        coalesce = 1'b1;
        m_be[i]  = be_reg[i] | push_be;
        for (int k = 0; k < 4; k++)
          if (push_be[k]) m_data[i][8*k +: 8] = push_data[8*k +: 8];
      end
    end
  end

  assign drain_valid = drain_req && (level_reg != '0);
  assign drain_word  = word_reg[0];
  assign drain_data  = m_data[0];
  assign drain_be    = m_be[0];

  always_comb begin
    word_next  = word_reg;
    data_next  = m_data;
    be_next    = m_be;
    level_next = level_reg;
    if (drain_valid) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        word_next[i] = word_next[i+1];
        data_next[i] = data_next[i+1];
        be_next[i]   = be_next[i+1];
      end
      level_next = level_reg - LW'(1);
    end
    if (push && !coalesce) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (int'(level_next) == i) begin
          word_next[i] = push_word;
          data_next[i] = push_data;
          be_next[i]   = push_be;
        end
      end
      level_next = level_next + LW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      level_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_reg[i] <= '0;
        data_reg[i] <= '0;
        be_reg[i]   <= '0;
      end
    end else begin
      level_reg <= level_next;
      word_reg  <= word_next;
      data_reg  <= data_next;
      be_reg    <= be_next;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
    logic [7:0] lane_data;
    always_comb begin
      lane_data = fwd_base[8*gi +: 8];
      for (int i = 0; i < DEPTH; i++)
        if (i < int'(level_reg) && word_reg[i] == fwd_word && be_reg[i][gi])
          lane_data = data_reg[i][8*gi +: 8];
    end
    assign fwd_data[8*gi +: 8] = lane_data;
  end

  assign level = level_reg;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side end of the MEM-stage data interface: word RAM behind a coalescing write buffer,
// zero-latency forwarded reads, sticky flag for dropped misaligned stores.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WB_DEPTH   = 2,
  localparam int LW        = $clog2(WB_DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [31:0]   data_address_2DM,
  input  logic [31:0]   data_write_2DM,
  input  logic [1:0]    data_write_size_2DM,
  input  logic          MemRead_2DM,
  input  logic          MemWrite_2DM,
  output logic [31:0]   data_read_fDM,
  output logic [LW-1:0] wb_level,
  output logic          misalign_err
);

  logic [31:0] ram [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] word;
  logic [1:0]            offset;
  lane_dec_t             dec;
  logic [31:0]           ram_rdata;
  logic                  drain_req;
  logic                  drain_valid;
  logic [ADDR_WIDTH-1:0] drain_word;
  logic [31:0]           drain_data;
  logic [3:0]            drain_be;
  logic                  unused_addr_bits;

  assign word             = data_address_2DM[ADDR_WIDTH+1:2];
  assign offset           = data_address_2DM[1:0];
  assign unused_addr_bits = ^data_address_2DM[31:ADDR_WIDTH+2];
  assign dec              = lane_decode(data_write_size_2DM, offset);
  assign ram_rdata        = ram[word];

  // The single RAM port belongs to reads whenever MemRead is up; a store issued alongside
  // a read only forces a drain once the buffer is full, so it can never overflow.
  assign drain_req = !MemRead_2DM || (MemWrite_2DM && int'(wb_level) == WB_DEPTH);

  dm_write_buffer #(
    .AW    (ADDR_WIDTH),
    .DEPTH (WB_DEPTH)
  ) u_wb (
    .CLK         (CLK),
    .RESET       (RESET),
    .push        (MemWrite_2DM && dec.legal),
    .push_word   (word),
    .push_data   (lane_align(data_write_size_2DM, offset, data_write_2DM)),
    .push_be     (dec.be),
    .drain_req   (drain_req),
    .drain_valid (drain_valid),
    .drain_word  (drain_word),
    .drain_data  (drain_data),
    .drain_be    (drain_be),
    .fwd_word    (word),
    .fwd_base    (ram_rdata),
    .fwd_data    (data_read_fDM),
    .level       (wb_level)
  );

  always_ff @(posedge CLK) begin
    if (drain_valid)
      for (int k = 0; k < 4; k++)
        if (drain_be[k]) ram[drain_word][8*k +: 8] <= drain_data[8*k +: 8];
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      misalign_err <= 1'b0;
    else if (MemWrite_2DM && !dec.legal)
      misalign_err <= 1'b1;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboarded bench: a byte-level memory model with an in-order pending-store queue predicts
// each cycle's read data, buffer level and error flag; a negedge monitor compares.
module tb_data_mem_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic [31:0]   data_address_2DM = '0;
  logic [31:0]   data_write_2DM = '0;
  logic [1:0]    data_write_size_2DM = '0;
  logic          MemRead_2DM = 1'b0;
  logic          MemWrite_2DM = 1'b0;
  logic [31:0]   data_read_fDM;
  logic [LW-1:0] wb_level;
  logic          misalign_err;

  data_mem_responder #(.ADDR_WIDTH(AW), .WB_DEPTH(DEPTH)) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .data_address_2DM    (data_address_2DM),
    .data_write_2DM      (data_write_2DM),
    .data_write_size_2DM (data_write_size_2DM),
    .MemRead_2DM         (MemRead_2DM),
    .MemWrite_2DM        (MemWrite_2DM),
    .data_read_fDM       (data_read_fDM),
    .wb_level            (wb_level),
    .misalign_err        (misalign_err)
  );

  always #5 CLK = ~CLK;

  // Lane l of a word holds bits [31-8l -: 8]; m[l] marks lane l as written.
  typedef struct {
    int        word;
    bit [31:0] d;
    bit [3:0]  m;
  } pend_t;

  typedef struct {
    bit        rd;
    bit [31:0] d;
    bit [31:0] km;
    int        lvl;
    bit        err;
  } exp_t;

  pend_t     pend[$];
  bit [31:0] ram_d[int];
  bit [3:0]  ram_k[int];
  bit        m_err;
  exp_t      exp_q[$];
  string     tag_q[$];
  int        vectors = 0;
  int        fails = 0;

  function automatic int sh(input int lane);
    return 8 * (3 - lane);
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) & ((32'd1 << AW) - 1));
  endfunction

  task automatic model_read(input logic [31:0] addr, output bit [31:0] d, output bit [31:0] km);
    int w;
    w  = word_of(addr);
    d  = '0;
    km = '0;
    if (ram_k.exists(w))
      for (int l = 0; l < 4; l++)
        if (ram_k[w][l]) begin
          d[sh(l) +: 8]  = ram_d[w][sh(l) +: 8];
          km[sh(l) +: 8] = 8'hFF;
        end
    foreach (pend[i])
      if (pend[i].word == w)
        for (int l = 0; l < 4; l++)
          if (pend[i].m[l]) begin
            d[sh(l) +: 8]  = pend[i].d[sh(l) +: 8];
            km[sh(l) +: 8] = 8'hFF;
          end
  endtask

  task automatic model_edge(input bit wr, input bit rd, input logic [31:0] addr,
                            input logic [31:0] data, input logic [1:0] size);
    int    a, n, w;
    bit    legal, drain, coal;
    pend_t np, t;
    a     = int'(addr[1:0]);
    n     = (size == 2'd0) ? 4 : int'(size);
    w     = word_of(addr);
    legal = (a + n <= 4) && !(size == 2'd2 && (a % 2) != 0);
    drain = pend.size() > 0 && (!rd || (wr && pend.size() == DEPTH));
    coal  = 1'b0;
    np.word = w;
    np.d    = '0;
    np.m    = '0;
    for (int j = 0; j < n; j++) begin
      np.d[sh(a + j) +: 8] = 8'(data >> (8 * (n - 1 - j)));
      np.m[a + j]          = 1'b1;
    end
    if (wr && legal && pend.size() > 0 && pend[pend.size()-1].word == w) begin
      t = pend[pend.size()-1];
      for (int l = 0; l < 4; l++)
        if (np.m[l]) begin
          t.d[sh(l) +: 8] = np.d[sh(l) +: 8];
          t.m[l]          = 1'b1;
        end
      pend[pend.size()-1] = t;
      coal = 1'b1;
    end
    if (drain) begin
      t = pend.pop_front();
      if (!ram_d.exists(t.word)) begin
        ram_d[t.word] = '0;
        ram_k[t.word] = '0;
      end
      for (int l = 0; l < 4; l++)
        if (t.m[l]) begin
          ram_d[t.word][sh(l) +: 8] = t.d[sh(l) +: 8];
          ram_k[t.word][l]          = 1'b1;
        end
    end
    if (wr && legal && !coal) pend.push_back(np);
    if (wr && !legal) m_err = 1'b1;
  endtask

  task automatic cycle(input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] size, input string tag);
    exp_t e;
    @(posedge CLK);
    #1;
    MemWrite_2DM        = wr;
    MemRead_2DM         = rd;
    data_address_2DM    = addr;
    data_write_2DM      = data;
    data_write_size_2DM = size;
    e.rd  = rd && !wr;
    e.lvl = pend.size();
    e.err = m_err;
    model_read(addr, e.d, e.km);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    model_edge(wr, rd, addr, data, size);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, "idle");
  endtask

  task automatic check_reset_state(input string tag);
    vectors++;
    if (wb_level !== '0) begin
      fails++;
      $display("FAIL %s wb_level: got %0d want 0", tag, wb_level);
    end
    vectors++;
    if (misalign_err !== 1'b0) begin
      fails++;
      $display("FAIL %s misalign_err: got %0b want 0", tag, misalign_err);
    end
  endtask

  // Reset lands mid-cycle, after the edge that consumed the previous cycle's inputs.
  task automatic do_reset(input string tag);
    @(posedge CLK);
    #1;
    MemWrite_2DM = 1'b0;
    MemRead_2DM  = 1'b0;
    #2;
    RESET = 1'b0;
    pend.delete();
    m_err = 1'b0;
    #1;
    check_reset_state(tag);
    @(posedge CLK);
    #3;
    RESET = 1'b1;
  endtask

  initial begin : monitor
    exp_t  e;
    string tag;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        vectors++;
        if (int'(wb_level) != e.lvl) begin
          fails++;
          $display("FAIL %s wb_level: got %0d want %0d", tag, wb_level, e.lvl);
        end
        vectors++;
        if (misalign_err !== e.err) begin
          fails++;
          $display("FAIL %s misalign_err: got %0b want %0b", tag, misalign_err, e.err);
        end
        if (e.rd) begin
          vectors++;
          if ((data_read_fDM & e.km) !== (e.d & e.km)) begin
            fails++;
            $display("FAIL %s read @%h: got %h want %h (mask %h)", tag, data_address_2DM,
                     data_read_fDM, e.d, e.km);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] addr, data;
    logic [1:0]  size;
    int          op;
    bit          rd;
    m_err = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_state("power_on_reset");
    @(posedge CLK);
    #3;
    RESET = 1'b1;

    // Store forwarding, then sub-word coalescing onto the same word.
    cycle(1, 0, 32'h10, 32'hDEADBEEF, 2'd0, "t1_sw");
    cycle(0, 1, 32'h10, 32'h0, 2'd0, "t1_lw_fwd");
    cycle(1, 0, 32'h13, 32'h000000AA, 2'd1, "t2_sb");
    cycle(1, 0, 32'h10, 32'h00001234, 2'd2, "t2_sh");
    idle(3);
    cycle(0, 1, 32'h10, 32'h0, 2'd0, "t2_lw");

    // Reads hold two pending stores in place; idle cycles drain them one per edge.
    cycle(1, 0, 32'h40, 32'h40404040, 2'd0, "t3_pre");
    idle(2);
    cycle(1, 1, 32'h80, 32'h11112222, 2'd0, "t3_sw0");
    cycle(1, 1, 32'h84, 32'h33334444, 2'd0, "t3_sw1");
    for (int i = 0; i < 4; i++) cycle(0, 1, 32'h40, 32'h0, 2'd0, "t3_lw_hold");
    cycle(0, 1, 32'h84, 32'h0, 2'd0, "t3_lw_fwd");
    idle(3);
    cycle(0, 1, 32'h80, 32'h0, 2'd0, "t3_lw_ram");

    // Misaligned half and three-byte stores are dropped and latch the error.
    cycle(1, 0, 32'h20, 32'h55667788, 2'd0, "t4_pre");
    idle(2);
    cycle(1, 0, 32'h21, 32'h0000BBCC, 2'd2, "t4_sh_bad");
    cycle(1, 0, 32'h22, 32'h00DDEEFF, 2'd3, "t4_3b_bad");
    idle(2);
    cycle(0, 1, 32'h20, 32'h0, 2'd0, "t4_lw");
    cycle(1, 0, 32'h29, 32'h00A1B2C3, 2'd3, "t4_3b_ok");
    idle(2);
    cycle(0, 1, 32'h28, 32'h0, 2'd0, "t4_lw_3b");

    // Full buffer plus a new word: drain and push on the same edge.
    cycle(1, 1, 32'h100, 32'hA0A0A0A0, 2'd0, "t5_fill0");
    cycle(1, 1, 32'h104, 32'hB1B1B1B1, 2'd0, "t5_fill1");
    cycle(1, 1, 32'h108, 32'hC2C2C2C2, 2'd0, "t5_full_sw");
    cycle(1, 1, 32'h109, 32'h0000005A, 2'd1, "t5_full_coal");
    cycle(0, 1, 32'h108, 32'h0, 2'd0, "t5_lw");
    idle(3);
    for (int i = 0; i < 3; i++) cycle(0, 1, 32'h100 + 32'(4 * i), 32'h0, 2'd0, "t5_lw_ram");

    // Asynchronous reset discards pending stores and clears the error flag.
    cycle(1, 0, 32'h200, 32'h01020304, 2'd0, "t6_pre0");
    cycle(1, 0, 32'h204, 32'h05060708, 2'd0, "t6_pre1");
    idle(2);
    cycle(1, 1, 32'h200, 32'hFFFF0000, 2'd0, "t6_sw0");
    cycle(1, 1, 32'h204, 32'h0000FFFF, 2'd0, "t6_sw1");
    do_reset("t6_async_reset");
    cycle(0, 1, 32'h200, 32'h0, 2'd0, "t6_lw0");
    cycle(0, 1, 32'h204, 32'h0, 2'd0, "t6_lw1");

    // Random traffic over a small word window, with aliased upper address bits.
    for (int i = 0; i < 8; i++) cycle(1, 0, 32'h300 + 32'(4 * i), $urandom, 2'd0, "rnd_init");
    idle(2);
    for (int n = 0; n < 1500; n++) begin
      if (n % 500 == 499) do_reset("rnd_reset");
      op   = int'($urandom_range(0, 9));
      addr = ($urandom & 32'hFFFF_F000) | 32'h300 | (32'($urandom_range(0, 7)) << 2);
      data = $urandom;
      size = 2'($urandom_range(0, 3));
      rd   = 1'($urandom_range(0, 1));
      if (op < 4)      cycle(1, rd, addr | 32'($urandom_range(0, 3)), data, size, "rnd_wr");
      else if (op < 8) cycle(0, 1, addr, 32'h0, 2'd0, "rnd_rd");
      else             cycle(0, 0, addr, 32'h0, 2'd0, "rnd_idle");
    end
    idle(4);
    for (int i = 0; i < 8; i++) cycle(0, 1, 32'h300 + 32'(4 * i), 32'h0, 2'd0, "rnd_final");

    @(posedge CLK);
    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
